// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctan table, gain, FSM encoding.
// Angles are Q15.16 degrees.
package cordic_pkg;

    localparam int ITW = 4;

    localparam logic [31:0] CORDIC_K = 32'h0000_9B75;

    // atan(2^-i) in degrees, Q15.16
    localparam logic [31:0] ATAN_TABLE [16] = '{
        32'h002D_0000, 32'h001A_90A7, 32'h000E_0947, 32'h0007_2001,
        32'h0003_938B, 32'h0001_CA38, 32'h0000_E52A, 32'h0000_7297,
        32'h0000_394C, 32'h0000_1CA6, 32'h0000_0E53, 32'h0000_0729,
        32'h0000_0395, 32'h0000_01CA, 32'h0000_00E5, 32'h0000_0073
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_microrot.sv
// One combinational rotation-mode CORDIC step.
// Direction follows the sign of the residual angle.
module cordic_microrot #(
    parameter int DATAWIDTH = 32
) (
    input  logic signed [DATAWIDTH-1:0] x,
    input  logic signed [DATAWIDTH-1:0] y,
    input  logic signed [DATAWIDTH-1:0] z,
    input  logic        [3:0]           iter,
    input  logic signed [DATAWIDTH-1:0] atan,
    output logic signed [DATAWIDTH-1:0] x_n,
    output logic signed [DATAWIDTH-1:0] y_n,
    output logic signed [DATAWIDTH-1:0] z_n
);

    logic signed [DATAWIDTH-1:0] xs;
    logic signed [DATAWIDTH-1:0] ys;
    logic                        neg;

    assign xs  = x >>> iter;
    assign ys  = y >>> iter;
    assign neg = z[DATAWIDTH-1];

    assign x_n = neg ? (x + ys) : (x - ys);
    assign y_n = neg ? (y - xs) : (y + xs);
    assign z_n = neg ? (z + atan) : (z - atan);

endmodule

// File: rtl/cordic_rot_sched.sv
// Iterative CORDIC rotator shared by two requesters,
// round-robin arbitration, one micro-rotation per clock.
module cordic_rot_sched #(
    parameter int DATAWIDTH = 32,
    parameter int N         = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic        [1:0]             req_valid,
    input  logic        [2*DATAWIDTH-1:0] req_angle,
    output logic        [1:0]             req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_id,
    output logic signed [DATAWIDTH-1:0]   out_cos,
    output logic signed [DATAWIDTH-1:0]   out_sin,
    output logic signed [DATAWIDTH-1:0]   out_zres,
    output logic                          busy
);

    import cordic_pkg::*;

    localparam logic [ITW-1:0] ITER_LAST = ITW'(N - 1);

    state_t                      state;
    state_t                      state_nx;
    logic                        rr_ptr;
    logic        [ITW-1:0]       iter;
    logic                        id;
    logic signed [DATAWIDTH-1:0] x;
    logic signed [DATAWIDTH-1:0] y;
    logic signed [DATAWIDTH-1:0] z;
    logic signed [DATAWIDTH-1:0] x_n;
    logic signed [DATAWIDTH-1:0] y_n;
    logic signed [DATAWIDTH-1:0] z_n;
    logic signed [DATAWIDTH-1:0] atan_w;
    logic signed [DATAWIDTH-1:0] ang_sel;
    logic        [1:0]           grant;

    assign atan_w  = DATAWIDTH'(ATAN_TABLE[iter]);
    assign ang_sel = grant[1] ? req_angle[2*DATAWIDTH-1:DATAWIDTH]
                              : req_angle[DATAWIDTH-1:0];

    cordic_microrot #(
        .DATAWIDTH (DATAWIDTH)
    ) u_rot (
        .x    (x),
        .y    (y),
        .z    (z),
        .iter (iter),
        .atan (atan_w),
        .x_n  (x_n),
        .y_n  (y_n),
        .z_n  (z_n)
    );

    always_comb begin
        grant    = 2'b00;
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                // rr_ptr has priority; the other side wins only alone
                if (req_valid[rr_ptr]) begin
                    grant[rr_ptr] = 1'b1;
                end else if (req_valid[~rr_ptr]) begin
                    grant[~rr_ptr] = 1'b1;
                end
                if (|grant) begin
                    state_nx = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                if (iter == ITER_LAST) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign req_ready = grant;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= 1'b0;
            iter     <= '0;
            id       <= 1'b0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            out_id   <= 1'b0;
            out_cos  <= '0;
            out_sin  <= '0;
            out_zres <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && |grant) begin
                x      <= DATAWIDTH'(CORDIC_K);
                y      <= '0;
                z      <= ang_sel;
                id     <= grant[1];
                iter   <= '0;
                rr_ptr <= ~grant[1];
            end
            if (state == ST_ROTATE) begin
                x    <= x_n;
                y    <= y_n;
                z    <= z_n;
                iter <= iter + 1'b1;
                // result image only moves on the final step
                if (iter == ITER_LAST) begin
                    out_cos  <= x_n;
                    out_sin  <= y_n;
                    out_zres <= z_n;
                    out_id   <= id;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_rot_sched.sv
// Directed and randomized bench for cordic_rot_sched.
// Expected trig values are hand-computed or from a real model.
module tb_cordic_rot_sched;

    localparam int W   = 32;
    localparam int NIT = 10;
    localparam int TOL = 32'h400;
    localparam real PI = 3.14159265358979;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [2*W-1:0]  req_angle;
    logic [1:0]      req_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_id;
    logic [W-1:0]    out_cos;
    logic [W-1:0]    out_sin;
    logic [W-1:0]    out_zres;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    cordic_rot_sched #(.DATAWIDTH(W), .N(NIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_zres  (out_zres),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ang;
        logic [31:0] ecos;
        logic [31:0] esin;
        bit          id;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input bit ok,
                       input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int absd(input logic [31:0] a,
                                input logic [31:0] b);
        int d;
        d = int'(a) - int'(b);
        return (d < 0) ? -d : d;
    endfunction

    task automatic do_req(input int id, input logic [31:0] ang,
                          output int lat);
        int n;
        req_angle[id*W +: W] = ang;
        req_valid[id] = 1'b1;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            tick();
            n++;
        end
        chk("grant_wait", req_ready[id], n, 0);
        tick();
        req_valid[id] = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int          lat;
    logic [31:0] snap_c, snap_s, snap_z;
    bit          held, multi, seen;
    int          gq[$];
    int          gc[$];
    int          oq[$];
    logic [31:0] oc[$];

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_angle = '0;
        out_ready = 1'b1;
        tick();
        chk("rst_ready", req_ready == 2'b00, req_ready, 0);
        chk("rst_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        tick();
        rst = 1'b0;
        chk("rst_cos", out_cos == 0, out_cos, 0);
        chk("rst_sin", out_sin == 0, out_sin, 0);
        chk("rst_zres", out_zres == 0, out_zres, 0);
        chk("rst_id", out_id == 1'b0, out_id, 0);

        // ---- table: single requester, full handshake ----
        vt[0] = '{32'h001E_0000, 32'h0000_DDB4, 32'h0000_8000, 1'b0};
        vt[1] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vt[2] = '{32'hFFA6_0000, 32'h0000_0000, 32'hFFFF_0000, 1'b0};
        vt[3] = '{32'h003C_0000, 32'h0000_8000, 32'h0000_DDB4, 1'b1};
        vt[4] = '{32'hFFD3_0000, 32'h0000_B505, 32'hFFFF_4AFB, 1'b1};
        vt[5] = '{32'h005A_0000, 32'h0000_0000, 32'h0001_0000, 1'b0};
        vt[6] = '{32'hFFE2_0000, 32'h0000_DDB4, 32'hFFFF_8000, 1'b0};

        for (int k = 0; k < 7; k++) begin
            do_req(int'(vt[k].id), vt[k].ang, lat);
            chk($sformatf("lat%0d", k), lat == NIT + 1, lat, NIT + 1);
            chk($sformatf("cos%0d", k),
                absd(out_cos, vt[k].ecos) <= TOL, out_cos, vt[k].ecos);
            chk($sformatf("sin%0d", k),
                absd(out_sin, vt[k].esin) <= TOL, out_sin, vt[k].esin);
            chk($sformatf("zres%0d", k),
                absd(out_zres, 0) <= 32'h1D00, out_zres, 0);
            chk($sformatf("id%0d", k), out_id == vt[k].id, out_id, vt[k].id);
            tick();
            chk($sformatf("drop%0d", k), !out_valid, out_valid, 0);
        end

        // ---- contention from reset: alternate grants ----
        req_valid = 2'b00;
        do_reset();
        req_angle = {32'h003C_0000, 32'h001E_0000};
        req_valid = 2'b11;
        out_ready = 1'b1;
        multi = 1'b0;
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (req_ready == 2'b11) multi = 1'b1;
            if (req_ready != 2'b00) begin
                gq.push_back(int'(req_ready[1]));
                gc.push_back(cyc);
            end
            if (out_valid) begin
                oq.push_back(int'(out_id));
                oc.push_back(out_cos);
            end
            tick();
        end
        req_valid = 2'b00;
        chk("rr_onehot", !multi, multi, 0);
        chk("rr_ngrant", gq.size() >= 4, gq.size(), 4);
        chk("rr_nout", oq.size() >= 4, oq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            int g, o;
            logic [31:0] c, e;
            g = (gq.size() > k) ? gq[k] : -1;
            o = (oq.size() > k) ? oq[k] : -1;
            c = (oc.size() > k) ? oc[k] : 32'hDEAD;
            e = (k % 2 == 0) ? 32'h0000_DDB4 : 32'h0000_8000;
            chk($sformatf("rr_grant%0d", k), g == k % 2, g, k % 2);
            chk($sformatf("rr_oid%0d", k), o == k % 2, o, k % 2);
            chk($sformatf("rr_cos%0d", k), absd(c, e) <= TOL, c, e);
        end
        chk("rr_period", gc.size() >= 2 && gc[1] - gc[0] == NIT + 2,
            (gc.size() >= 2) ? gc[1] - gc[0] : -1, NIT + 2);

        // ---- back-pressure in DONE ----
        for (int n = 0; n < 20 && busy; n++) tick();
        out_ready = 1'b0;
        do_req(1, 32'hFFD3_0000, lat);
        chk("bp_valid", out_valid, out_valid, 1);
        snap_c = out_cos;
        snap_s = out_sin;
        snap_z = out_zres;
        req_angle[W-1:0] = 32'h001E_0000;
        req_valid[0] = 1'b1;
        held = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!out_valid || out_cos != snap_c || out_sin != snap_s ||
                out_zres != snap_z || req_ready != 2'b00 || out_id != 1'b1)
                held = 1'b0;
        end
        chk("bp_held", held, held, 1);
        chk("bp_cos", absd(snap_c, 32'h0000_B505) <= TOL,
            snap_c, 32'h0000_B505);
        out_ready = 1'b1;
        tick();
        chk("bp_release", !out_valid, out_valid, 0);
        chk("bp_regrant", req_ready == 2'b01, req_ready, 1);
        tick();
        req_valid = 2'b00;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp_next_lat", lat == NIT + 1, lat, NIT + 1);
        chk("bp_next_cos", absd(out_cos, 32'h0000_DDB4) <= TOL,
            out_cos, 32'h0000_DDB4);
        tick();

        // ---- reset during ROTATE ----
        req_angle[W-1:0] = 32'h003C_0000;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 20 && !req_ready[0]; n++) tick();
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 4; n++) tick();
        chk("mid_busy", busy, busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", !out_valid, out_valid, 0);
        chk("mid_busy0", !busy, busy, 0);
        chk("mid_ready", req_ready == 2'b00, req_ready, 0);
        chk("mid_cos", out_cos == 0, out_cos, 0);
        chk("mid_sin", out_sin == 0, out_sin, 0);
        chk("mid_zres", out_zres == 0, out_zres, 0);
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("mid_quiet", !seen, seen, 0);
        req_valid = 2'b11;
        #1;
        chk("mid_rrptr", req_ready == 2'b01, req_ready, 1);
        req_valid = 2'b00;
        do_req(0, 32'h001E_0000, lat);
        chk("mid_lat", lat == NIT + 1, lat, NIT + 1);
        chk("mid_cos2", absd(out_cos, 32'h0000_DDB4) <= TOL,
            out_cos, 32'h0000_DDB4);
        chk("mid_sin2", absd(out_sin, 32'h0000_8000) <= TOL,
            out_sin, 32'h0000_8000);
        tick();

        // ---- random angles vs real model, scoreboarded ----
        begin
            int          issued, got, cyc, ai;
            bit [1:0]    hs;
            bit          qid[$];
            logic [31:0] qang[$];
            bit          ok, eid;
            logic [31:0] eang;
            real         ad, ec, es, dc, ds;

            issued = 0;
            got    = 0;
            cyc    = 0;
            hs     = 2'b00;
            multi  = 1'b0;
            while (got < 1000 && cyc < 40000) begin
                for (int i = 0; i < 2; i++) begin
                    if (hs[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && issued < 1000 &&
                        $urandom_range(0, 3) == 0) begin
                        ai = int'($urandom_range(0, 180 * 65536)) - 90 * 65536;
                        req_angle[i*W +: W] = ai;
                        req_valid[i] = 1'b1;
                        issued++;
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                hs = req_valid & req_ready;
                if (req_ready == 2'b11) multi = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    if (hs[i]) begin
                        qid.push_back(i[0]);
                        qang.push_back(req_angle[i*W +: W]);
                    end
                end
                if (out_valid && out_ready) begin
                    if (qid.size() == 0) begin
                        chk("rand_spurious", 1'b0, got, -1);
                    end else begin
                        eid  = qid.pop_front();
                        eang = qang.pop_front();
                        ad = real'(int'(eang)) / 65536.0;
                        ec = $cos(ad * PI / 180.0) * 65536.0;
                        es = $sin(ad * PI / 180.0) * 65536.0;
                        dc = real'(int'(out_cos)) - ec;
                        ds = real'(int'(out_sin)) - es;
                        if (dc < 0.0) dc = -dc;
                        if (ds < 0.0) ds = -ds;
                        ok = (dc <= 1536.0) && (ds <= 1536.0) &&
                             (out_id == eid);
                        chk($sformatf("rand%0d ang=%h id=%0d sin=%h",
                                      got, eang, out_id, out_sin),
                            ok, out_cos, longint'($rtoi(ec)));
                    end
                    got++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            req_valid = 2'b00;
            chk("rand_count", got == 1000, got, 1000);
            chk("rand_onehot", !multi, multi, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
